mux_nx1_rr: RTL and testbench

//  Parametrised N:1 channel multiplexer with valid/ready handshake on every input and a

---
 rtl/mux_nx1_rr.sv | 99 +++++++++
 tb/tb_mux_nx1_rr.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_rr.sv
// N:1 valid/ready channel multiplexer with a registered output stage.
// Channels are picked either by sel (fixed mode) or round-robin from the last granted channel.
module mux_nx1_rr #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      rr_mode,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
);

  logic [SEL_W-1:0] rr_ptr;
  logic             hi_vld;
  logic             lo_vld;
  logic [SEL_W-1:0] hi_idx;
  logic [SEL_W-1:0] lo_idx;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             load;
  logic             xfer;

  // Round-robin: the lowest valid channel above the pointer wins; failing that,
  // the lowest valid channel overall, which is the wrap-around continuation.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_valid[i] && !hi_vld && (i > int'(rr_ptr))) begin
        hi_vld = 1'b1;
        hi_idx = SEL_W'(i);
      end
      if (in_valid[i] && !lo_vld) begin
        lo_vld = 1'b1;
        lo_idx = SEL_W'(i);
      end
    end
  end

  // An out-of-range sel simply never matches, so it yields no grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (rr_mode) begin
      grant_vld = hi_vld || lo_vld;
      grant_idx = hi_vld ? hi_idx : lo_idx;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if ((sel == SEL_W'(i)) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end
    grant_vld = grant_vld && rst_n;
  end

  assign load = !out_valid || out_ready;
  assign xfer = load && grant_vld;

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = xfer && (grant_idx == SEL_W'(i));
      if (grant_idx == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      rr_ptr    <= SEL_W'(CHANNELS - 1);
    end else if (xfer) begin
      out_data  <= grant_data;
      out_valid <= 1'b1;
      out_chan  <= grant_idx;
      rr_ptr    <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Bench for mux_nx1_rr: directed scenarios plus random traffic against a behavioural model.
module tb_mux_nx1_rr;
  localparam int W  = 2;
  localparam int C  = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [C*W-1:0] in_data;
  logic [C-1:0]  in_valid;
  logic [C-1:0]  in_ready;
  logic [SW-1:0] sel;
  logic          rr_mode;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_chan;

  int n_cmp = 0;
  int n_mis = 0;

  // Model state: what the output register must hold, and the last granted channel.
  int m_ptr   = C - 1;
  int m_valid = 0;
  int m_data  = 0;
  int m_chan  = 0;

  int seq_a[5] = '{0, 1, 2, 3, 0};
  int seq_b[4] = '{1, 3, 1, 3};

  mux_nx1_rr #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .rr_mode  (rr_mode),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_chan (out_chan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Channel the spec says is granted right now, or -1.
  function automatic int exp_grant();
    if (rst_n !== 1'b1) return -1;
    if ((m_valid != 0) && (out_ready !== 1'b1)) return -1;
    if (rr_mode) begin
      for (int k = 1; k <= C; k++) begin
        int idx;
        idx = (m_ptr + k) % C;
        if (in_valid[idx]) return idx;
      end
      return -1;
    end
    if ((int'(sel) < C) && in_valid[sel]) return int'(sel);
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr   = C - 1;
      m_valid = 0;
      m_data  = 0;
      m_chan  = 0;
    end else begin
      int g;
      g = exp_grant();
      if (g >= 0) begin
        m_data  = int'(in_data[g*W +: W]);
        m_chan  = g;
        m_valid = 1;
        m_ptr   = g;
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    g = exp_grant();
    chk("out_valid", int'(out_valid), m_valid);
    chk("out_data", int'(out_data), m_data);
    chk("out_chan", int'(out_chan), m_chan);
    chk("in_ready", int'(in_ready), (g < 0) ? 0 : (1 << g));
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_data   = {2'b00, 2'b11, 2'b10, 2'b01};
    sel       = 2'd0;
    rr_mode   = 1'b0;
    out_ready = 1'b1;

    // 1: reset holds everything quiet even with all channels valid
    repeat (3) @(negedge clk);
    chk("t1_out_valid", int'(out_valid), 0);
    chk("t1_out_data", int'(out_data), 0);
    chk("t1_in_ready", int'(in_ready), 0);
    #2 rst_n = 1'b1;
    #1 chk("t1_rdy_nonzero", int'(in_ready != 4'b0000), 1);

    // 2: fixed mode, selected channel valid
    @(negedge clk);
    #2;
    sel      = 2'd2;
    in_valid = 4'b0100;
    in_data  = {2'b00, 2'b10, 2'b10, 2'b01};
    #1 chk("t2_in_ready", int'(in_ready), 4);
    @(negedge clk);
    chk("t2_out_data", int'(out_data), 2);
    chk("t2_out_chan", int'(out_chan), 2);
    chk("t2_out_valid", int'(out_valid), 1);

    // 3: fixed mode, selected channel idle
    #2;
    sel      = 2'd1;
    in_valid = 4'b1101;
    #1 chk("t3_in_ready", int'(in_ready), 0);
    @(negedge clk);
    chk("t3_out_valid", int'(out_valid), 0);

    // fresh pointer for the fairness check
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2;
    rst_n     = 1'b1;
    rr_mode   = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;

    // 4: round-robin fairness
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_chan_all", int'(out_chan), seq_a[k]);
    end
    #2 in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_chan_odd", int'(out_chan), seq_b[k]);
    end

    // 5: backpressure after ch0 delivers 2'b01
    #2 in_valid = 4'b1111;
    @(negedge clk);
    chk("t5_first_data", int'(out_data), 1);
    chk("t5_first_chan", int'(out_chan), 0);
    #2 out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_hold_data", int'(out_data), 1);
      chk("t5_hold_valid", int'(out_valid), 1);
      chk("t5_hold_ready", int'(in_ready), 0);
    end
    #2 out_ready = 1'b1;
    #1 chk("t5_resume_ready", int'(in_ready), 2);

    // 6: asynchronous reset mid-stream
    @(negedge clk);
    chk("t6_valid_before", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid_async", int'(out_valid), 0);
    chk("t6_ready_async", int'(in_ready), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_first_chan", int'(out_chan), 0);
    chk("t6_first_valid", int'(out_valid), 1);

    // random traffic, checked every cycle against the model
    repeat (3000) begin
      @(negedge clk);
      #2;
      in_valid  = C'($urandom);
      in_data   = (C*W)'($urandom);
      sel       = SW'($urandom_range(0, C - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1 chk("rand_async_reset", int'(out_valid), 0);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
